// File: rtl/cm_ucie_d2d_alsm_pkg.sv
// Shared definitions for the multi-stack D2D RX adapter link state machine:
// UCIe 4-bit RDI/FDI state encodings, per-stack FSM states, FDI mapping.
package cm_ucie_d2d_alsm_pkg;

    localparam logic [3:0] ST_RESET     = 4'b0000;
    localparam logic [3:0] ST_ACTIVE    = 4'b0001;
    localparam logic [3:0] ST_LINKERROR = 4'b1010;
    localparam logic [3:0] ST_RETRAIN   = 4'b1011;

    typedef enum logic [2:0] {
        S_RESET,
        S_BRINGUP,
        S_ACTIVE,
        S_RETRAIN,
        S_LINKERROR
    } alsm_st_e;

    // Bringup is still RESET from the FDI point of view.
    function automatic logic [3:0] fdi_enc(input alsm_st_e s);
        case (s)
            S_ACTIVE:    return ST_ACTIVE;
            S_RETRAIN:   return ST_RETRAIN;
            S_LINKERROR: return ST_LINKERROR;
            default:     return ST_RESET;
        endcase
    endfunction

endpackage

// File: rtl/cm_ucie_d2d_rx_alsm_lane.sv
// One stack's ALSM: RDI tracking, bringup handshake with timeout, FDI state.
// Ports: i_clk/i_rstn/i_swrst/i_en control, i_rdi/i_done in; o_sts/o_start/
// o_timeout registered out, o_nxt next state for aggregation.
// Optional CM_UCIE_ALSM_RETRAIN_CNT_EN adds o_retrain_cnt (saturating).
module cm_ucie_d2d_rx_alsm_lane
    import cm_ucie_d2d_alsm_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024,
    parameter int TO_W        = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_swrst,
    input  logic       i_en,
    input  logic [3:0] i_rdi,
    input  logic       i_done,
    output logic [3:0] o_sts,
    output logic       o_start,
    output logic       o_timeout,
    output alsm_st_e   o_nxt
`ifdef CM_UCIE_ALSM_RETRAIN_CNT_EN
    ,
    output logic [7:0] o_retrain_cnt
`endif
);

    alsm_st_e        r_state;
    logic [TO_W-1:0] r_cnt;
    logic [3:0]      r_sts;
    logic            r_start;
    logic            r_to;

    alsm_st_e        w_nxt;
    logic [TO_W-1:0] w_cnt_nxt;
    logic            w_start;
    logic            w_to;
    logic            w_rdi_act;
    logic            w_rdi_err;
    logic            w_rdi_rtr;
    logic            w_rdi_rst;

    assign w_rdi_act = (i_rdi == ST_ACTIVE);
    assign w_rdi_err = (i_rdi == ST_LINKERROR);
    assign w_rdi_rtr = (i_rdi == ST_RETRAIN);
    // Unknown RDI encodings collapse to RESET.
    assign w_rdi_rst = !(w_rdi_act || w_rdi_err || w_rdi_rtr);

    always_comb begin
        w_nxt     = r_state;
        w_cnt_nxt = '0;
        w_start   = 1'b0;
        w_to      = 1'b0;
        if (i_swrst || !i_en) begin
            w_nxt = S_RESET;
        end else if (w_rdi_err) begin
            w_nxt = S_LINKERROR;
        end else begin
            case (r_state)
                S_RESET: begin
                    if (w_rdi_act) begin
                        w_nxt   = S_BRINGUP;
                        w_start = 1'b1;
                    end
                end
                S_BRINGUP: begin
                    // done beats a coincident timeout
                    if (i_done) begin
                        w_nxt = S_ACTIVE;
                    end else if (r_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        w_nxt = S_LINKERROR;
                        w_to  = 1'b1;
                    end else if (!w_rdi_act) begin
                        w_nxt = S_RESET;
                    end else begin
                        w_cnt_nxt = r_cnt + TO_W'(1);
                    end
                end
                S_ACTIVE: begin
                    if (w_rdi_rtr)      w_nxt = S_RETRAIN;
                    else if (w_rdi_rst) w_nxt = S_RESET;
                end
                S_RETRAIN: begin
                    if (w_rdi_act)      w_nxt = S_ACTIVE;
                    else if (w_rdi_rst) w_nxt = S_RESET;
                end
                S_LINKERROR: begin
                    if (w_rdi_rst) w_nxt = S_RESET;
                end
                default: w_nxt = S_RESET;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= S_RESET;
            r_cnt   <= '0;
            r_sts   <= ST_RESET;
            r_start <= 1'b0;
            r_to    <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sts   <= fdi_enc(w_nxt);
            r_start <= w_start;
            r_to    <= w_to;
        end
    end

`ifdef CM_UCIE_ALSM_RETRAIN_CNT_EN
    logic [7:0] r_rcnt;

    // Survives stack disable; only resets clear it.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_rcnt <= '0;
        end else if (i_swrst) begin
            r_rcnt <= '0;
        end else if (r_state == S_ACTIVE && w_nxt == S_RETRAIN
                     && r_rcnt != 8'hFF) begin
            r_rcnt <= r_rcnt + 8'd1;
        end
    end

    assign o_retrain_cnt = r_rcnt;
`endif

    assign o_sts     = r_sts;
    assign o_start   = r_start;
    assign o_timeout = r_to;
    assign o_nxt     = w_nxt;

endmodule

// File: rtl/cm_ucie_d2d_rx_alsm_multi.sv
// Multi-stack D2D RX ALSM: N_STACK lanes plus registered link-level flags.
// Ports: clk_i, rstn_i, swrst_i, stack_en_i, rdi_state_sts_i, bringup_done_i
// in; state_sts_o, bringup_start_o, timeout_o, all_active_o, any_error_o out.
// Optional CM_UCIE_ALSM_RETRAIN_CNT_EN adds retrain_cnt_o (8 bits/stack).
module cm_ucie_d2d_rx_alsm_multi
    import cm_ucie_d2d_alsm_pkg::*;
#(
    parameter int N_STACK     = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   swrst_i,
    input  logic [N_STACK-1:0]     stack_en_i,
    input  logic [4*N_STACK-1:0]   rdi_state_sts_i,
    output logic [4*N_STACK-1:0]   state_sts_o,
    output logic [N_STACK-1:0]     bringup_start_o,
    input  logic [N_STACK-1:0]     bringup_done_i,
    output logic [N_STACK-1:0]     timeout_o,
    output logic                   all_active_o,
    output logic                   any_error_o
`ifdef CM_UCIE_ALSM_RETRAIN_CNT_EN
    ,
    output logic [8*N_STACK-1:0]   retrain_cnt_o
`endif
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    alsm_st_e w_nxt [N_STACK];
    logic     w_all;
    logic     w_any;
    logic     r_all;
    logic     r_any;

    for (genvar g = 0; g < N_STACK; g++) begin : g_lane
        cm_ucie_d2d_rx_alsm_lane #(
            .TIMEOUT_CYC (TIMEOUT_CYC),
            .TO_W        (TO_W)
        ) u_lane (
            .i_clk         (clk_i),
            .i_rstn        (rstn_i),
            .i_swrst       (swrst_i),
            .i_en          (stack_en_i[g]),
            .i_rdi         (rdi_state_sts_i[4*g+:4]),
            .i_done        (bringup_done_i[g]),
            .o_sts         (state_sts_o[4*g+:4]),
            .o_start       (bringup_start_o[g]),
            .o_timeout     (timeout_o[g]),
            .o_nxt         (w_nxt[g])
`ifdef CM_UCIE_ALSM_RETRAIN_CNT_EN
            ,
            .o_retrain_cnt (retrain_cnt_o[8*g+:8])
`endif
        );
    end

    // Built from next states so the flags line up with state_sts_o.
    always_comb begin
        w_all = |stack_en_i;
        w_any = 1'b0;
        for (int k = 0; k < N_STACK; k++) begin
            if (stack_en_i[k]) begin
                if (w_nxt[k] != S_ACTIVE)   w_all = 1'b0;
                if (w_nxt[k] == S_LINKERROR) w_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_all <= 1'b0;
            r_any <= 1'b0;
        end else begin
            r_all <= w_all;
            r_any <= w_any;
        end
    end

    assign all_active_o = r_all;
    assign any_error_o  = r_any;

endmodule

// File: tb/tb_cm_ucie_d2d_rx_alsm_multi.sv
// Self-checking bench for cm_ucie_d2d_rx_alsm_multi (N_STACK=2, TIMEOUT=16).
// Directed scenarios then random traffic against a cycle reference model.
module tb_cm_ucie_d2d_rx_alsm_multi;

    localparam int NS  = 2;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          swrst = 1'b0;
    logic [NS-1:0] en = '0;
    logic [NS-1:0] done = '0;
    logic [4*NS-1:0] rdi = '0;
    logic [4*NS-1:0] sts;
    logic [NS-1:0] start;
    logic [NS-1:0] tmo;
    logic          all_act;
    logic          any_err;
`ifdef CM_UCIE_ALSM_RETRAIN_CNT_EN
    logic [8*NS-1:0] rcnt;
`endif

    cm_ucie_d2d_rx_alsm_multi #(
        .N_STACK     (NS),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk_i           (clk),
        .rstn_i          (rstn),
        .swrst_i         (swrst),
        .stack_en_i      (en),
        .rdi_state_sts_i (rdi),
        .state_sts_o     (sts),
        .bringup_start_o (start),
        .bringup_done_i  (done),
        .timeout_o       (tmo),
        .all_active_o    (all_act),
        .any_error_o     (any_err)
`ifdef CM_UCIE_ALSM_RETRAIN_CNT_EN
        ,
        .retrain_cnt_o   (rcnt)
`endif
    );

    always #5 clk = ~clk;

    int     n_tests = 0;
    int     n_fail  = 0;
    longint cyc     = 0;

    // Link modes as the stack is seen from outside.
    typedef enum int {M_IDLE, M_WAIT, M_UP, M_RTR, M_ERR} mode_t;
    mode_t         m_mode [NS];
    longint        m_t0   [NS];
    int            m_rc   [NS];
    logic [NS-1:0] m_start;
    logic [NS-1:0] m_to;
    logic          m_all;
    logic          m_any;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] fdi_of(input mode_t m);
        case (m)
            M_UP:    return 4'h1;
            M_RTR:   return 4'hB;
            M_ERR:   return 4'hA;
            default: return 4'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NS; k++) begin
            m_mode[k] = M_IDLE;
            m_t0[k]   = 0;
            m_rc[k]   = 0;
        end
        m_start = '0;
        m_to    = '0;
        m_all   = 1'b0;
        m_any   = 1'b0;
    endtask

    task automatic model_step();
        logic [3:0] r;
        for (int k = 0; k < NS; k++) begin
            r = rdi[4*k+:4];
            if (!(r == 4'h1 || r == 4'hA || r == 4'hB)) r = 4'h0;
            m_start[k] = 1'b0;
            m_to[k]    = 1'b0;
            if (swrst) m_rc[k] = 0;
            if (swrst || !en[k]) begin
                m_mode[k] = M_IDLE;
            end else if (r == 4'hA) begin
                m_mode[k] = M_ERR;
            end else begin
                case (m_mode[k])
                    M_IDLE: if (r == 4'h1) begin
                        m_mode[k]  = M_WAIT;
                        m_t0[k]    = cyc;
                        m_start[k] = 1'b1;
                    end
                    M_WAIT: begin
                        if (done[k]) m_mode[k] = M_UP;
                        else if (cyc - m_t0[k] == TMO) begin
                            m_mode[k] = M_ERR;
                            m_to[k]   = 1'b1;
                        end else if (r != 4'h1) m_mode[k] = M_IDLE;
                    end
                    M_UP: begin
                        if (r == 4'hB) begin
                            m_mode[k] = M_RTR;
                            if (m_rc[k] < 255) m_rc[k]++;
                        end else if (r == 4'h0) m_mode[k] = M_IDLE;
                    end
                    M_RTR: begin
                        if (r == 4'h1)      m_mode[k] = M_UP;
                        else if (r == 4'h0) m_mode[k] = M_IDLE;
                    end
                    default: if (r == 4'h0) m_mode[k] = M_IDLE;
                endcase
            end
        end
        m_all = (en != '0);
        m_any = 1'b0;
        for (int k = 0; k < NS; k++) begin
            if (en[k] && m_mode[k] != M_UP)  m_all = 1'b0;
            if (en[k] && m_mode[k] == M_ERR) m_any = 1'b1;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NS; k++) begin
            chk($sformatf("sts%0d", k), 32'(sts[4*k+:4]), 32'(fdi_of(m_mode[k])));
            chk($sformatf("start%0d", k), 32'(start[k]), 32'(m_start[k]));
            chk($sformatf("tmo%0d", k), 32'(tmo[k]), 32'(m_to[k]));
`ifdef CM_UCIE_ALSM_RETRAIN_CNT_EN
            chk($sformatf("rcnt%0d", k), 32'(rcnt[8*k+:8]), 32'(m_rc[k]));
`endif
        end
        chk("all_active", 32'(all_act), 32'(m_all));
        chk("any_error", 32'(any_err), 32'(m_any));
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        check_all();
    endtask

    logic [3:0] rtab [7] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'hA, 4'hB, 4'h5};

    initial begin
        model_reset();
        #12;
        chk("rst_sts", 32'(sts), 32'h0);
        chk("rst_start", 32'(start), 32'h0);
        chk("rst_tmo", 32'(tmo), 32'h0);
        chk("rst_all", 32'(all_act), 32'h0);
        chk("rst_any", 32'(any_err), 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        // Bringup on both stacks, done at +3 and +12.
        en  = 2'b11;
        rdi = 8'h11;
        step();
        chk("t1_start", 32'(start), 32'h3);
        for (int i = 1; i <= 13; i++) begin
            done = {i == 12, i == 3};
            step();
            if (i == 3)  chk("t1_sts0", 32'(sts[3:0]), 32'h1);
            if (i == 11) chk("t1_all_lo", 32'(all_act), 32'h0);
            if (i == 12) begin
                chk("t1_sts1", 32'(sts[7:4]), 32'h1);
                chk("t1_all_hi", 32'(all_act), 32'h1);
            end
        end
        done = '0;

        // Retrain for 5 cycles.
        rdi[3:0] = 4'hB;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rt_sts", 32'(sts[3:0]), 32'hB);
        end
        rdi[3:0] = 4'h1;
        step();
        chk("rt_back", 32'(sts[3:0]), 32'h1);
        chk("rt_nostart", 32'(start), 32'h0);
`ifdef CM_UCIE_ALSM_RETRAIN_CNT_EN
        chk("rt_cnt", 32'(rcnt[7:0]), 32'h1);
`endif

        // Bringup timeout.
        rdi[3:0] = 4'h0;
        step();
        rdi[3:0] = 4'h1;
        step();
        chk("to_start", 32'(start[0]), 32'h1);
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 15) chk("to_early", 32'(tmo[0]), 32'h0);
        end
        chk("to_pulse", 32'(tmo[0]), 32'h1);
        chk("to_sts", 32'(sts[3:0]), 32'hA);
        chk("to_any", 32'(any_err), 32'h1);
        for (int i = 0; i < 3; i++) step();
        chk("to_sticky", 32'(sts[3:0]), 32'hA);
        rdi[3:0] = 4'h0;
        step();
        chk("to_exit", 32'(sts[3:0]), 32'h0);

        // Done coincides with counter expiry.
        rdi[3:0] = 4'h1;
        step();
        for (int i = 1; i <= 16; i++) begin
            done[0] = (i == 16);
            step();
        end
        done = '0;
        chk("race_sts", 32'(sts[3:0]), 32'h1);
        chk("race_tmo", 32'(tmo[0]), 32'h0);

        // Masking.
        en = 2'b01;
        rdi[7:4] = 4'h0;
        step();
        chk("mask_all", 32'(all_act), 32'h1);
        chk("mask_sts1", 32'(sts[7:4]), 32'h0);
        en = 2'b00;
        step();
        chk("mask_sts0", 32'(sts[3:0]), 32'h0);
        chk("mask_all0", 32'(all_act), 32'h0);

        // Soft reset mid-bringup and in ACTIVE.
        en = 2'b01;
        step();
        step();
        swrst = 1'b1;
        step();
        chk("sw_sts", 32'(sts[3:0]), 32'h0);
        swrst = 1'b0;
        step();
        chk("sw_restart", 32'(start[0]), 32'h1);
        step();
        done[0] = 1'b1;
        step();
        done[0] = 1'b0;
        chk("sw_act", 32'(sts[3:0]), 32'h1);
        swrst = 1'b1;
        step();
        chk("sw_sts2", 32'(sts[3:0]), 32'h0);
        swrst = 1'b0;
        step();
        chk("sw_restart2", 32'(start[0]), 32'h1);
        step();

        // Async reset mid-bringup.
        #2 rstn = 1'b0;
        #1;
        model_reset();
        chk("arst_sts", 32'(sts), 32'h0);
        chk("arst_start", 32'(start), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rdi  = 8'h00;
        rstn = 1'b1;
        step();

        // Random traffic.
        en = 2'b11;
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < NS; k++) begin
                if ($urandom_range(7) == 0)
                    rdi[4*k+:4] = rtab[$urandom_range(6)];
                done[k] = ($urandom_range(11) == 0);
            end
            swrst = ($urandom_range(99) == 0);
            if ($urandom_range(59) == 0) en = NS'($urandom_range(3));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
